// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU stage: function codes, FSM states,
// Z register control encodings and the flag payload.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_NOT = 4'd5;
    localparam logic [3:0] FN_SLA = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;
    localparam logic [3:0] FN_SRA = 4'd8;
    localparam logic [3:0] FN_MUL = 4'd9;

    localparam logic [1:0] ZCTL_HOLD  = 2'b00;
    localparam logic [1:0] ZCTL_READ  = 2'b01;
    localparam logic [1:0] ZCTL_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic ovf;
    } alu_flags_t;

    // Ops that run on the iterative core rather than in a single cycle.
    function automatic logic is_iter_op(input logic [3:0] fn);
        return (fn == FN_SLA) || (fn == FN_SRL) || (fn == FN_SRA) || (fn == FN_MUL);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative engine: one-bit-per-cycle shifter and LSB-first shift-add multiplier.
// load captures operands, step advances one bit, last_c flags the final step.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_c,
    output logic             carry_c,
    output logic             last_c
);

    localparam int unsigned CNT_W = SHW + 1;

    logic [3:0]       func_q, func_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;

    // A zero shift count loads cnt=0: no step shifts, result stays a, carry 0.
    always_comb begin
        func_d   = func_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        if (load) begin
            func_d = func;
            cout_d = 1'b0;
            if (func == FN_MUL) begin
                acc_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                cnt_d    = CNT_W'(WIDTH);
            end else begin
                acc_d = a;
                cnt_d = CNT_W'(b[SHW-1:0]);
            end
        end else if (step && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            case (func_q)
                FN_SLA: begin
                    cout_d = acc_q[WIDTH-1];
                    acc_d  = {acc_q[WIDTH-2:0], 1'b0};
                end
                FN_SRL: begin
                    cout_d = acc_q[0];
                    acc_d  = {1'b0, acc_q[WIDTH-1:1]};
                end
                FN_SRA: begin
                    cout_d = acc_q[0];
                    acc_d  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                end
                FN_MUL: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            func_q   <= func_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
        end
    end

    // Expose the post-step value so the top can register it on the final edge.
    assign res_c   = acc_d;
    assign carry_c = cout_d;
    assign last_c  = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/multicycle_alu.sv
// Sequential ALU stage feeding the Z register: IDLE/EXEC/WRITE control, single-cycle
// ops, flags and Z control; shifts and multiply run on alu_iter_core.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             zread,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       zcontrol,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             ovf
);

    localparam int unsigned SUM_W = WIDTH + 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       func_q, func_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       zctl_q, zctl_d;
    alu_flags_t       flags_q, flags_d;

    logic             core_load_c, core_step_c, core_carry_c, core_last_c;
    logic [WIDTH-1:0] core_res_c;

    logic [SUM_W-1:0] sum_c;
    logic [WIDTH-1:0] sc_res_c;
    logic             sc_carry_c, sc_ovf_c, sc_valid_c;

    alu_iter_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load_c),
        .step    (core_step_c),
        .func    (func),
        .a       (a),
        .b       (b),
        .res_c   (core_res_c),
        .carry_c (core_carry_c),
        .last_c  (core_last_c)
    );

    // Single-cycle ops on the latched operands; SUB is a + ~b + 1 so carry is borrow-not.
    always_comb begin
        sum_c      = '0;
        sc_res_c   = '0;
        sc_carry_c = 1'b0;
        sc_ovf_c   = 1'b0;
        sc_valid_c = 1'b1;
        case (func_q)
            FN_ADD: begin
                sum_c      = {1'b0, a_q} + {1'b0, b_q};
                sc_res_c   = sum_c[WIDTH-1:0];
                sc_carry_c = sum_c[WIDTH];
                sc_ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            FN_SUB: begin
                sum_c      = {1'b0, a_q} + {1'b0, ~b_q} + SUM_W'(1);
                sc_res_c   = sum_c[WIDTH-1:0];
                sc_carry_c = sum_c[WIDTH];
                sc_ovf_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            FN_AND:  sc_res_c = a_q & b_q;
            FN_OR:   sc_res_c = a_q | b_q;
            FN_XOR:  sc_res_c = a_q ^ b_q;
            FN_NOT:  sc_res_c = ~a_q;
            default: sc_valid_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        func_d      = func_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        result_d    = result_q;
        flags_d     = flags_q;
        zctl_d      = ZCTL_HOLD;
        core_load_c = 1'b0;
        core_step_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d         = a;
                    b_d         = b;
                    func_d      = func;
                    core_load_c = 1'b1;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_iter_op(func_q)) begin
                    core_step_c = 1'b1;
                    if (core_last_c) begin
                        state_d       = ST_WRITE;
                        done_d        = 1'b1;
                        zctl_d        = ZCTL_WRITE;
                        result_d      = core_res_c;
                        flags_d.carry = core_carry_c;
                        flags_d.zero  = (core_res_c == '0);
                        flags_d.sign  = core_res_c[WIDTH-1];
                        flags_d.ovf   = 1'b0;
                    end
                end else begin
                    state_d  = ST_WRITE;
                    done_d   = 1'b1;
                    zctl_d   = ZCTL_WRITE;
                    result_d = sc_res_c;
                    flags_d  = '0;
                    if (sc_valid_c) begin
                        flags_d.carry = sc_carry_c;
                        flags_d.zero  = (sc_res_c == '0);
                        flags_d.sign  = sc_res_c[WIDTH-1];
                        flags_d.ovf   = sc_ovf_c;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        // Z read requests are honoured only while idle; otherwise they are dropped.
        if ((state_d == ST_IDLE) && zread) begin
            zctl_d = ZCTL_READ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zctl_q   <= ZCTL_HOLD;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zctl_q   <= zctl_d;
            flags_q  <= flags_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zcontrol = zctl_q;
    assign carry    = flags_q.carry;
    assign zero     = flags_q.zero;
    assign sign     = flags_q.sign;
    assign ovf      = flags_q.ovf;

endmodule
